// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader slice.
// Widths, opcode_type field position and loader state encoding.
package imem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int INSTR_W    = 32;
  localparam int BYTE_W     = 8;
  localparam int OPC_HI     = 31;
  localparam int OPC_LO     = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } ld_state_e;

  function automatic logic [1:0] opc_of(
    input logic [INSTR_W-1:0] w
  );
    return w[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles four bytes into one 32-bit word in the selected lane order.
// Flags the byte that completes a word; holds the word until refilled.
module imem_byte_packer
  import imem_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               byte_vld_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_done_o
);

  logic [1:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (byte_vld_i) begin
      cnt_d = cnt_q + 2'd1;
      // Little-endian: first byte migrates down to bits [7:0].
      if (LITTLE_ENDIAN)
        word_d = {byte_i, word_q[INSTR_W-1:BYTE_W]};
      else
        word_d = {word_q[INSTR_W-BYTE_W-1:0], byte_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = byte_vld_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader that fills instruction memory word by word,
// then verifies a trailing XOR checksum byte.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  word_count,
  input  logic               in_valid,
  input  logic [BYTE_W-1:0]  in_data,
  output logic               in_ready,
  output logic               wr_en,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic [1:0]         wr_opcode_type,
  output logic               busy,
  output logic               done,
  output logic               cksum_err
);

  ld_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  left_q, left_d;
  logic [BYTE_W-1:0]  xor_q, xor_d;
  logic               err_q, err_d;

  logic               pk_clr;
  logic               pk_vld;
  logic [INSTR_W-1:0] pk_word;
  logic               pk_done;

  imem_byte_packer #(
    .LITTLE_ENDIAN(LITTLE_ENDIAN)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (pk_clr),
    .byte_vld_i (pk_vld),
    .byte_i     (in_data),
    .word_o     (pk_word),
    .word_done_o(pk_done)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    xor_d    = xor_q;
    err_d    = err_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    pk_clr   = 1'b0;
    pk_vld   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          left_d  = word_count;
          xor_d   = '0;
          err_d   = 1'b0;
          pk_clr  = 1'b1;
          state_d = (word_count == '0) ? ST_CHECK : ST_RECV;
        end
      end
      ST_RECV: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pk_vld = 1'b1;
          xor_d  = xor_q ^ in_data;
          if (pk_done)
            state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          left_d  = left_q - ADDR_W'(1);
          state_d = (left_q == ADDR_W'(1)) ? ST_CHECK : ST_RECV;
        end
      end
      ST_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_data != xor_q)
            err_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      xor_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      xor_q   <= xor_d;
      err_q   <= err_d;
    end
  end

  assign wr_addr        = addr_q;
  assign wr_data        = pk_word;
  assign wr_opcode_type = opc_of(pk_word);
  assign busy           = (state_q != ST_IDLE);
  assign cksum_err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader.
// Expected writes/checksum come from a byte-list model of the load.
module tb_imem_loader;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [1:0]    wr_opcode_type;
  logic          busy;
  logic          done;
  logic          cksum_err;

  imem_loader #(
    .ADDR_W(AW),
    .LITTLE_ENDIAN(1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_opcode_type(wr_opcode_type),
    .busy          (busy),
    .done          (done),
    .cksum_err     (cksum_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] cap_addr[$];
  logic [31:0]   cap_data[$];
  logic [1:0]    cap_opc[$];
  int            done_cnt = 0;
  int            acc_cnt  = 0;
  int            wen_cnt  = 0;
  logic [7:0]    stim[$];

  // Observe the bus mid-cycle: what is seen here transfers at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en && wr_ready) begin
        cap_addr.push_back(wr_addr);
        cap_data.push_back(wr_data);
        cap_opc.push_back(wr_opcode_type);
      end
      if (wr_en) wen_cnt++;
      if (done) done_cnt++;
      if (in_valid && in_ready) acc_cnt++;
      if (wr_en) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL in_ready_in_write: got %b want 0", in_ready);
        end
      end
    end
  end

  task automatic make_stim(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    stim.delete();
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      x = x ^ b;
    end
    if (good) stim.push_back(x);
    else stim.push_back(x ^ 8'($urandom_range(255, 1)));
  endtask

  task automatic clear_obs();
    cap_addr.delete();
    cap_data.delete();
    cap_opc.delete();
    done_cnt = 0;
    acc_cnt  = 0;
    wen_cnt  = 0;
  endtask

  // Drives one whole load from stim[] and checks it against the model.
  task automatic load_scenario(input string nm, input logic [AW-1:0] b,
                               input logic [AW-1:0] c, input int vp,
                               input int rp);
    bit            to;
    bit            acc;
    int            cyc;
    int            idx;
    int            n;
    logic [7:0]    x;
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    n = int'(c);
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = c;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom); word_count = AW'($urandom);
    idx = 0; cyc = 0; to = 1'b0;
    while (done_cnt == 0 && !to) begin
      if (idx < stim.size()) begin
        in_valid = ($urandom_range(99) < vp);
        in_data  = stim[idx];
      end else begin
        in_valid = 1'b1;
        in_data  = 8'hA5;
      end
      wr_ready = ($urandom_range(99) < rp);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
      if (cyc > 4000) to = 1'b1;
    end
    in_valid = 1'b0; wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) x = x ^ stim[i];
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL %s timeout: got no done within budget, want done", nm);
    end
    n_checks++;
    if (cap_addr.size() != n) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d want %0d", nm, cap_addr.size(), n);
    end
    for (int w = 0; w < n && w < cap_addr.size(); w++) begin
      ea = b + AW'(w);
      ed = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
      n_checks++;
      if (cap_addr[w] !== ea) begin
        n_fail++;
        $display("FAIL %s addr[%0d]: got %h want %h", nm, w, cap_addr[w], ea);
      end
      n_checks++;
      if (cap_data[w] !== ed) begin
        n_fail++;
        $display("FAIL %s data[%0d]: got %h want %h", nm, w, cap_data[w], ed);
      end
      n_checks++;
      if (cap_opc[w] !== ed[31:30]) begin
        n_fail++;
        $display("FAIL %s opc[%0d]: got %b want %b", nm, w, cap_opc[w], ed[31:30]);
      end
    end
    n_checks++;
    if (acc_cnt != 4 * n + 1) begin
      n_fail++;
      $display("FAIL %s bytes_taken: got %0d want %0d", nm, acc_cnt, 4 * n + 1);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d want 1", nm, done_cnt);
    end
    n_checks++;
    if (cksum_err !== (x != stim[4*n])) begin
      n_fail++;
      $display("FAIL %s cksum_err: got %b want %b", nm, cksum_err, (x != stim[4*n]));
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after: got %b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b1; in_data = 8'h5A; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, wr_opcode_type, busy, done, cksum_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h o=%b busy=%b done=%b err=%b want all 0",
               in_ready, wr_en, wr_addr, wr_data, wr_opcode_type, busy, done, cksum_err);
    end
    #1; rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: got rdy=%b busy=%b want 0 0", in_ready, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; wr_ready = 1'b0;
  endtask

  task automatic test_single_word();
    stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    load_scenario("single", 16'h0010, 16'd1, 70, 60);
    n_checks++;
    if (cap_data.size() != 1 || cap_data[0] !== 32'h12345678 ||
        cap_addr[0] !== 16'h0010 || cap_opc[0] !== 2'b00) begin
      n_fail++;
      $display("FAIL single_exact: got n=%0d want 1 write 0010:12345678/00", cap_data.size());
    end
  endtask

  task automatic test_two_word_bad();
    stim = '{8'h11, 8'h22, 8'h33, 8'hC4, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    load_scenario("two_bad", 16'h0000, 16'd2, 80, 50);
    n_checks++;
    if (cap_data.size() != 2 || cap_data[0] !== 32'hC4332211 ||
        cap_data[1] !== 32'h88776655 || cap_opc[0] !== 2'b11 ||
        cap_opc[1] !== 2'b10 || cap_addr[1] !== 16'h0001) begin
      n_fail++;
      $display("FAIL two_bad_exact: got n=%0d want C4332211/11 @0 and 88776655/10 @1",
               cap_data.size());
    end
    n_checks++;
    if (cksum_err !== 1'b1) begin
      n_fail++;
      $display("FAIL two_bad_err: got %b want 1", cksum_err);
    end
  endtask

  task automatic test_backpressure();
    bit            acc;
    int            idx;
    int            cyc;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    logic [AW-1:0] b;
    b = AW'($urandom);
    make_stim(1, 1'b1);
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = 16'd1;
    @(posedge clk); #1;
    start = 1'b0; wr_ready = 1'b0; idx = 0; cyc = 0;
    forever begin
      in_valid = 1'b1; in_data = stim[idx];
      @(negedge clk);
      if (wr_en || cyc > 50) break;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    n_checks++;
    if (!wr_en) begin
      n_fail++;
      $display("FAIL bp_reach_write: got wr_en=0 want 1");
    end
    a0 = wr_addr; d0 = wr_data;
    n_checks++;
    if (a0 !== b || d0 !== {stim[3], stim[2], stim[1], stim[0]}) begin
      n_fail++;
      $display("FAIL bp_word: got %h:%h want %h:%h", a0, d0, b,
               {stim[3], stim[2], stim[1], stim[0]});
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = stim[4];
      @(negedge clk);
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== a0 || wr_data !== d0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got we=%b a=%h d=%h rdy=%b want 1 %h %h 0",
                 k, wr_en, wr_addr, wr_data, in_ready, a0, d0);
      end
    end
    n_checks++;
    if (acc_cnt != 4 || cap_addr.size() != 0) begin
      n_fail++;
      $display("FAIL bp_no_extra: got bytes=%0d writes=%0d want 4 0", acc_cnt, cap_addr.size());
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    wr_ready = 1'b0;
    n_checks++;
    if (cap_addr.size() != 1) begin
      n_fail++;
      $display("FAIL bp_release: got writes=%0d want 1", cap_addr.size());
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (done_cnt != 1 || cksum_err !== 1'b0 || acc_cnt != 5) begin
      n_fail++;
      $display("FAIL bp_finish: got done=%0d err=%b bytes=%0d want 1 0 5",
               done_cnt, cksum_err, acc_cnt);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_wrap();
    make_stim(2, 1'b1);
    load_scenario("wrap", 16'hFFFF, 16'd2, 90, 70);
    n_checks++;
    if (cap_addr.size() != 2 || cap_addr[0] !== 16'hFFFF || cap_addr[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_addr: got n=%0d want FFFF then 0000", cap_addr.size());
    end
  endtask

  task automatic test_zero_count();
    stim = '{8'h00};
    load_scenario("zero", AW'($urandom), 16'd0, 60, 100);
    n_checks++;
    if (wen_cnt != 0) begin
      n_fail++;
      $display("FAIL zero_no_wr_en: got %0d cycles want 0", wen_cnt);
    end
  endtask

  task automatic test_reset_midload();
    bit acc;
    int idx;
    int cyc;
    make_stim(1, 1'b0);
    load_scenario("pre_bad", AW'($urandom), 16'd1, 100, 100);
    make_stim(2, 1'b1);
    clear_obs();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0200; word_count = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; idx = 0; cyc = 0;
    while (idx < 2 && cyc < 20) begin
      in_valid = 1'b1; in_data = stim[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0; rst = 1'b1; wr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, wr_opcode_type, busy, done, cksum_err} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: got we=%b a=%h d=%h busy=%b err=%b want all 0",
               wr_en, wr_addr, wr_data, busy, cksum_err);
    end
    #1; rst = 1'b0; wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cap_addr.size() != 0 || wen_cnt != 0) begin
      n_fail++;
      $display("FAIL midload_no_write: got writes=%0d we_cycles=%0d want 0 0",
               cap_addr.size(), wen_cnt);
    end
    make_stim(2, 1'b1);
    load_scenario("after_reset", AW'($urandom), 16'd2, 75, 75);
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    int            n;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(5, 1);
      b = AW'($urandom);
      make_stim(n, $urandom_range(1, 0) == 1);
      load_scenario("random", b, AW'(n), $urandom_range(100, 30),
                    $urandom_range(100, 20));
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_word_bad();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of InstructionMemory: fills instruction memory with program words received as a byte stream (boot/debug loader).
- Assembles 4 bytes per 32-bit instruction, drives the memory write port with address, instruction and the opcode_type tag, then checks an XOR checksum byte at the end of the transfer.
- Sits between the host byte link (UART/debug bridge) and InstructionMemory's write port.

Parameters:
- ADDR_W, 16, instruction memory address width; addresses wrap modulo 2^ADDR_W.
- LITTLE_ENDIAN, 1, 1 = first received byte is instr[7:0]; 0 = first byte is instr[31:24].

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE
- base_addr  input  ADDR_W  first word address, sampled on accepted start
- word_count  input  ADDR_W  number of 32-bit words, sampled on accepted start
- in_valid  input  1  byte available
- in_data  input  8  byte value
- in_ready  output  1  loader accepts byte (transfer when in_valid && in_ready)
- wr_en  output  1  write request to instruction memory
- wr_ready  input  1  memory accepts write (transfer when wr_en && wr_ready)
- wr_addr  output  ADDR_W  word address
- wr_data  output  32  instruction word
- wr_opcode_type  output  2  equals wr_data[31:30]
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when the load finishes
- cksum_err  output  1  sticky; set if checksum mismatches, cleared on next accepted start

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Reset (including mid-load) forces IDLE.
- Reset values: all outputs 0. Internal byte counter, word counter, address and checksum are also 0.
- States: IDLE, RECV, WRITE, CHECK, DONE.
- IDLE:
  - in_ready = 0.
  - start latches base_addr and word_count and clears the running XOR and cksum_err.
  - If word_count == 0, go to CHECK; otherwise go to RECV.
  - start outside IDLE is ignored.
- RECV:
  - in_ready = 1.
  - Each accepted byte is shifted into the assembly register at the lane given by LITTLE_ENDIAN and XORed into the running checksum.
  - On the 4th byte, go to WRITE the next cycle.
- WRITE:
  - in_ready = 0. wr_en = 1; wr_addr, wr_data and wr_opcode_type are held stable until wr_ready.
  - On handshake: the address increments (wraps 0xFFFF -> 0x0000) and words-remaining decrements.
  - If words remain, go to RECV; otherwise go to CHECK.
  - Minimum 5 cycles per word (4 RECV + 1 WRITE).
- CHECK:
  - in_ready = 1. The next accepted byte is compared to the running XOR of all payload bytes.
  - Mismatch sets cksum_err. Either way, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. busy deasserts in the same cycle the state returns to IDLE.
- Simultaneous events:
  - in_valid in WRITE is not consumed.
  - Bytes presented in IDLE are not consumed.
  - wr_ready asserted without wr_en has no effect.
- Partial word at reset: discarded; nothing is written.

Decomposition:
- Shared package imem_pkg: ADDR_W default, INSTR_W = 32, the opcode_type field position (bits 31:30), and the loader state enum.
- One natural sub-module: imem_byte_packer. It handles byte-lane shift, the byte counter and the word-complete flag, and is reusable by a future readback/dump path.

Test Plan:
- Single word, little-endian: start, base 0x0010, count 1; bytes 0x78,0x56,0x34,0x12, then cksum 0x08 -> one write addr 0x0010, data 0x12345678, opcode_type 00; done pulse; cksum_err 0.
- Two words, bad checksum: base 0x0000, count 2; bytes 11 22 33 C4 55 66 77 88, then cksum 0x00 -> writes 0xC4332211 (opcode_type 11) @0x0000 and 0x88776655 (opcode_type 10) @0x0001; cksum_err 1 after done.
- Backpressure: wr_ready low for 5 cycles in WRITE -> wr_en, addr and data stable; in_ready 0; no extra bytes consumed; write completes on the first wr_ready cycle.
- Address wrap: base 0xFFFF, count 2 -> writes at 0xFFFF then 0x0000.
- Zero count: count 0 -> no wr_en; one checksum byte 0x00 accepted; done with cksum_err 0.
- Reset mid-load: rst after 2 bytes of word 0 -> all outputs 0, no write issued; a new start loads correctly and cksum_err from the prior load is cleared.
